lc3b_mem_unit: RTL
==================

# lc3b_mem_unit

Parametrised memory access unit for the LC-3b multicycle core, replacing the fixed MAR/MDR register pair and memory-side muxing with a self-sequencing block. It accepts one load or store request from the control FSM and drives the memory handshake until `mem_resp`. It supports word and byte accesses with lane steering and sign extension, plus indirect (pointer-then-target) accesses for LDI/STI. It sits between the datapath (ALU/PC address sources, regfile write data) and the memory port.

## Interface
- `WIDTH`, 16: data word width; multiple of 8, at least 16.
- `ADDR_WIDTH`, 16: byte address width.
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: start an access; sampled only in IDLE.
- `write` in 1: 1 = store, 0 = load.
- `byte_mode` in 1: 1 = byte access (LDB/STB), 0 = word.
- `indirect` in 1: 1 = `addr` points to a word holding the target address.
- `addr` in ADDR_WIDTH: effective address from the datapath.
- `wdata` in WIDTH: store data; byte stores use bits [7:0].
- `rdata` out WIDTH: load result; byte loads are sign-extended.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the access completes.
- `mem_address` out ADDR_WIDTH: registered address to memory.
- `mem_wdata` out WIDTH: registered, lane-steered store data.
- `mem_read`, `mem_write` out 1: memory strobes.
- `mem_byte_enable` out WIDTH/8: lane enables, valid while `mem_write` is high.
- `mem_rdata` in WIDTH: memory read data.
- `mem_resp` in 1: memory completion, valid while a strobe is high.

## Operation
- States: IDLE, PTR (indirect pointer read), ACCESS, DONE.
- Transitions:
  - IDLE + `req`: latch `write`, `byte_mode`, `indirect` and `wdata`; load `mem_address` from `addr`; go to PTR if `indirect`, else ACCESS.
  - PTR: `mem_read`=1, all byte enables set. On `mem_resp`, load `mem_address` from `mem_rdata[ADDR_WIDTH-1:0]` and go to ACCESS.
  - ACCESS: `mem_read`=!write or `mem_write`=write. On `mem_resp`, capture the load result into `rdata` and go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Word accesses force `mem_address[log2(WIDTH/8)-1:0]` to 0. The PTR read is always word-aligned. Byte accesses keep the full address.
- Byte lane `L` = `mem_address[log2(WIDTH/8)-1:0]`.
  - STB: `wdata[7:0]` is replicated to every lane; only bit `L` of `mem_byte_enable` is set.
  - STW: all enables set.
  - LDB: `rdata` = sign-extended `mem_rdata[8L+7:8L]`.
  - LDW: `rdata` = `mem_rdata`.
- `rdata` holds its value until the next load completes. Stores leave `rdata` unchanged.
- `req` is ignored while `busy` or in DONE. `mem_resp` is ignored in IDLE and DONE.
- `mem_resp` may stay asserted across cycles; only the first cycle in each state is acted on, because the state changes on that cycle.

## Timing
- Reset values: state IDLE; `rdata`, `mem_address`, `mem_wdata` = 0; `busy`, `done`, `mem_read`, `mem_write`, `mem_byte_enable` = 0.
- Reset mid-access abandons the transaction. Strobes are low on the cycle after `reset` is sampled, and no `done` is produced.
- Strobes, `mem_address`, `mem_wdata` and `mem_byte_enable` are registered or derived only from state. There is no combinational path from `req`/`addr` to the memory port.
- Direct access: `req` sampled at edge 0, strobe high in cycle 1. If `mem_resp` arrives in cycle 1, `done` is high in cycle 2 with `rdata` valid. Minimum req→done is 2 cycles; each wait cycle adds 1.
- Indirect access: minimum 3 cycles (PTR, ACCESS, DONE).
- Strobes drop in the cycle after `mem_resp`. There is never a strobe in DONE.
- `req` asserted in the DONE cycle is lost. The control FSM re-issues it.

## Structure
- Add to `lc3b_types`: `lc3b_mem_state` enum (IDLE, PTR, ACCESS, DONE) and `lc3b_mem_req` struct (write, byte_mode, indirect).
- Sub-module `byte_steer` (combinational, parametrised by WIDTH): store replication, byte-enable decode, load lane select and sign extension.

## Test plan
- Word load, zero wait: `addr`=16'h3001, `mem_rdata`=16'hBEEF, `mem_resp` in the first strobe cycle. Required: `mem_address`=16'h3000, `done` at cycle 2, `rdata`=16'hBEEF.
- Byte load, high lane: `addr`=16'h0041, `mem_rdata`=16'h80FF. Required: `rdata`=16'hFF80. With `addr`=16'h0040, required: `rdata`=16'hFFFF.
- Byte store: `addr`=16'h0103, `wdata`=16'h12A5. Required: `mem_wdata`=16'hA5A5, `mem_byte_enable`=2'b10, `mem_write` held through 3 wait cycles, `done` one cycle after `mem_resp`.
- Indirect load: `addr`=16'h0010, pointer read returns 16'h4000, target read returns 16'h1234. Required: second `mem_address`=16'h4000, `rdata`=16'h1234, req→done = 3 cycles with zero wait.
- `req` pulsed while busy and in DONE; spurious `mem_resp` in IDLE. Required: no extra access, no state change.
- `reset` during ACCESS with `mem_read` high. Required: strobes and `busy` low the next cycle, no `done`, `rdata`=0; a new `req` then completes normally.
- WIDTH=32 regression: byte store to `addr`[1:0]=2'b10. Required: `mem_byte_enable`=4'b0100.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory-unit sequencer states and the latched request bundle.
package lc3b_types;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PTR,
        S_ACCESS,
        S_DONE
    } lc3b_mem_state;

    typedef struct packed {
        logic write;
        logic byte_mode;
        logic indirect;
    } lc3b_mem_req;

endpackage

// File: rtl/lc3b_mem_unit_byte_steer.sv
// Byte-lane steering: store replication, byte-enable decode, load lane select
// and sign extension. Purely combinational.
module byte_steer #(
    parameter int WIDTH = 16,
    localparam int NB = WIDTH / 8,
    localparam int LW = $clog2(NB)
) (
    input  logic             byte_mode,
    input  logic [LW-1:0]    lane,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] wdata_steered,
    output logic [NB-1:0]    lane_be,
    output logic [WIDTH-1:0] rdata_ext
);

    logic [7:0] sel;

    always_comb begin
        wdata_steered = byte_mode ? {NB{wdata[7:0]}} : wdata;
        lane_be       = byte_mode ? (NB'(1) << lane) : '1;
        sel           = mem_rdata[{lane, 3'b000} +: 8];
        rdata_ext     = byte_mode ? {{(WIDTH-8){sel[7]}}, sel} : mem_rdata;
    end

endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b memory access unit: sequences one word/byte, direct/indirect
// load or store through the memory handshake.
module lc3b_mem_unit
    import lc3b_types::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  write,
    input  logic                  byte_mode,
    input  logic                  indirect,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WIDTH/8-1:0]    mem_byte_enable,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_resp
);

    localparam int NB = WIDTH / 8;
    localparam int LW = $clog2(NB);

    lc3b_mem_state         state_q, state_d;
    lc3b_mem_req           req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0]      st_wdata, ld_data;
    logic [NB-1:0]         lane_be;

    byte_steer #(.WIDTH(WIDTH)) u_steer (
        .byte_mode     (req_q.byte_mode),
        .lane          (addr_q[LW-1:0]),
        .wdata         (wdata_q),
        .mem_rdata     (mem_rdata),
        .wdata_steered (st_wdata),
        .lane_be       (lane_be),
        .rdata_ext     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    req_d.write     = write;
                    req_d.byte_mode = byte_mode;
                    req_d.indirect  = indirect;
                    wdata_d         = wdata;
                    // Pointer reads and word accesses are always word-aligned.
                    if (byte_mode && !indirect)
                        addr_d = addr;
                    else
                        addr_d = {addr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
                    state_d = indirect ? S_PTR : S_ACCESS;
                end
            end
            S_PTR: begin
                if (mem_resp) begin
                    if (req_q.byte_mode)
                        addr_d = mem_rdata[ADDR_WIDTH-1:0];
                    else
                        addr_d = {mem_rdata[ADDR_WIDTH-1:LW], {LW{1'b0}}};
                    state_d = S_ACCESS;
                end else if (!req_q.indirect) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_resp) begin
                    if (!req_q.write)
                        rdata_d = ld_data;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        case (state_q)
            S_PTR: begin
                mem_read        = 1'b1;
                mem_byte_enable = '1;
            end
            S_ACCESS: begin
                mem_read        = !req_q.write;
                mem_write       = req_q.write;
                mem_byte_enable = lane_be;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign rdata       = rdata_q;
    assign mem_address = addr_q;
    assign mem_wdata   = st_wdata;

endmodule
